// File: rtl/vt52_pkg.sv
// Shared constants, FSM state encoding and the modulo-SIZE address helper
// for the VT52 command engine.
package vt52_pkg;

  localparam logic [7:0] ESC   = 8'h1B;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] HT    = 8'h09;
  localparam logic [7:0] SPACE = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ESC,
    S_ESC_Y_ROW,
    S_ESC_Y_COL,
    S_FILL
  } state_t;

  // Operands are always below 2*size, so one conditional subtract is enough.
  function automatic logic [31:0] addr_wrap(input logic [31:0] a, input logic [31:0] size);
    return (a >= size) ? a - size : a;
  endfunction

endpackage

// File: rtl/vt52_fill_seq.sv
// Space-fill address sequencer: emits one address per cycle from a latched
// start for a latched count, wrapping at SIZE. Reset loads a full-screen fill.
module vt52_fill_seq
  import vt52_pkg::*;
#(
  parameter int ADDR_BITS = 11,
  parameter int SIZE      = 2000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 go,
  input  logic [ADDR_BITS-1:0] start,
  input  logic [ADDR_BITS:0]   count,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 strobe,
  output logic                 done
);

  logic [ADDR_BITS:0] remaining;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr      <= '0;
      remaining <= (ADDR_BITS+1)'(SIZE);
    end else if (go) begin
      addr      <= start;
      remaining <= count;
    end else if (remaining != '0) begin
      addr      <= ADDR_BITS'(addr_wrap(32'(addr) + 32'd1, 32'(SIZE)));
      remaining <= remaining - (ADDR_BITS+1)'(1);
    end
  end

  assign strobe = (remaining != '0);
  assign done   = (remaining == '0);

endmodule

// File: rtl/vt52_cmd_engine.sv
// VT52 byte-stream interpreter driving char buffer, scroll base and cursor.
// Optional macro TAB_EN: HT advances the cursor to the next tab stop.
//
// state       | meaning
// S_IDLE      | waiting for a printable char or control code
// S_ESC       | ESC seen, waiting for the command letter
// S_ESC_Y_ROW | ESC Y seen, waiting for the row byte
// S_ESC_Y_COL | row latched, waiting for the column byte
// S_FILL      | fill sequencer writing spaces, input stalled
module vt52_cmd_engine
  import vt52_pkg::*;
#(
  parameter int ROWS      = 25,
  parameter int COLS      = 80,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11,
  parameter int TAB_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [7:0]           data,
  input  logic                 valid,
  output logic                 ready,
  output logic [ADDR_BITS-1:0] new_first_char,
  output logic                 new_first_char_wen,
  output logic [7:0]           new_char,
  output logic [ADDR_BITS-1:0] new_char_address,
  output logic                 new_char_wen,
  output logic [COL_BITS-1:0]  new_cursor_x,
  output logic [ROW_BITS-1:0]  new_cursor_y,
  output logic                 new_cursor_wen
);

  localparam int SIZE = ROWS * COLS;
  localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(COLS - 1);

  if (SIZE > 2**ADDR_BITS || TAB_WIDTH < 1) begin : g_bad_cfg
    $error("vt52_cmd_engine: geometry does not fit ADDR_BITS or TAB_WIDTH < 1");
  end

  state_t               state, state_n;
  logic [COL_BITS-1:0]  x, x_n;
  logic [ROW_BITS-1:0]  y, y_n, row_latch, row_n;
  logic [ADDR_BITS-1:0] first_char, fc_n;
  logic                 nl_pend, nl_n;
  logic                 wr_n, fcw_n, scroll, accept;
  logic [ADDR_BITS-1:0] wr_addr_n;
  logic [7:0]           wr_char_n;

  logic                 fill_go, fill_strobe, fill_done;
  logic [ADDR_BITS-1:0] fill_start, fill_addr;
  logic [ADDR_BITS:0]   fill_count;

  logic [31:0]          cur_offset;
  logic [ADDR_BITS-1:0] cur_addr, fc_next;

  function automatic logic [31:0] clamp_coord(input logic [7:0] b, input int lim);
    logic [31:0] v;
    v = (b < SPACE) ? 32'd0 : 32'(b - SPACE);
    return (v > 32'(lim)) ? 32'(lim) : v;
  endfunction

  assign cur_offset = 32'(y) * 32'(COLS) + 32'(x);
  assign cur_addr   = ADDR_BITS'(addr_wrap(32'(first_char) + cur_offset, 32'(SIZE)));
  assign fc_next    = ADDR_BITS'(addr_wrap(32'(first_char) + 32'(COLS), 32'(SIZE)));

  // A pending corner newline holds off input for one cycle so the char write,
  // the cursor/scroll pulse and the bottom-row fill land in that order.
  assign ready  = (state inside {S_IDLE, S_ESC, S_ESC_Y_ROW, S_ESC_Y_COL}) && !nl_pend;
  assign accept = valid && ready;

`ifdef TAB_EN
  logic [31:0] tab_stop;
  always_comb begin
    tab_stop = 32'(x) + 32'(TAB_WIDTH) - (32'(x) % 32'(TAB_WIDTH));
    if (tab_stop > 32'(COLS - 1)) tab_stop = 32'(COLS - 1);
  end
`endif

  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    fc_n       = first_char;
    row_n      = row_latch;
    nl_n       = 1'b0;
    wr_n       = 1'b0;
    wr_addr_n  = cur_addr;
    wr_char_n  = data;
    fcw_n      = 1'b0;
    scroll     = 1'b0;
    fill_go    = 1'b0;
    fill_start = cur_addr;
    fill_count = '0;

    case (state)
      S_IDLE: begin
        if (nl_pend) begin
          x_n    = '0;
          scroll = 1'b1;
        end else if (accept) begin
          if (data >= SPACE && data <= 8'h7E) begin
            wr_n = 1'b1;
            if (x != COL_MAX) begin
              x_n = x + COL_BITS'(1);
            end else if (y != ROW_MAX) begin
              x_n = '0;
              y_n = y + ROW_BITS'(1);
            end else begin
              nl_n = 1'b1;
            end
          end else begin
            case (data)
              CR:  x_n = '0;
              LF:  if (y != ROW_MAX) y_n = y + ROW_BITS'(1);
                   else scroll = 1'b1;
              BS:  if (x != '0) x_n = x - COL_BITS'(1);
              ESC: state_n = S_ESC;
`ifdef TAB_EN
              HT:  x_n = COL_BITS'(tab_stop);
`endif
              default: ;
            endcase
          end
        end
      end

      S_ESC: begin
        if (accept) begin
          state_n = S_IDLE;
          case (data)
            8'h41: if (y != '0) y_n = y - ROW_BITS'(1);
            8'h42: if (y != ROW_MAX) y_n = y + ROW_BITS'(1);
            8'h43: if (x != COL_MAX) x_n = x + COL_BITS'(1);
            8'h44: if (x != '0) x_n = x - COL_BITS'(1);
            8'h48: begin
              x_n = '0;
              y_n = '0;
            end
            8'h45: begin
              x_n        = '0;
              y_n        = '0;
              fill_go    = 1'b1;
              fill_start = first_char;
              fill_count = (ADDR_BITS+1)'(SIZE);
              state_n    = S_FILL;
            end
            8'h4A: begin
              fill_go    = 1'b1;
              fill_count = (ADDR_BITS+1)'(32'(SIZE) - cur_offset);
              state_n    = S_FILL;
            end
            8'h4B: begin
              fill_go    = 1'b1;
              fill_count = (ADDR_BITS+1)'(32'(COLS) - 32'(x));
              state_n    = S_FILL;
            end
            8'h59: state_n = S_ESC_Y_ROW;
            default: ;
          endcase
        end
      end

      S_ESC_Y_ROW: begin
        if (accept) begin
          row_n   = ROW_BITS'(clamp_coord(data, ROWS - 1));
          state_n = S_ESC_Y_COL;
        end
      end

      S_ESC_Y_COL: begin
        if (accept) begin
          y_n     = row_latch;
          x_n     = COL_BITS'(clamp_coord(data, COLS - 1));
          state_n = S_IDLE;
        end
      end

      S_FILL: begin
        wr_n      = fill_strobe;
        wr_addr_n = fill_addr;
        wr_char_n = SPACE;
        if (fill_done) state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase

    // New bottom row occupies the addresses of the old top row.
    if (scroll) begin
      fc_n       = fc_next;
      fcw_n      = 1'b1;
      fill_go    = 1'b1;
      fill_start = first_char;
      fill_count = (ADDR_BITS+1)'(COLS);
      state_n    = S_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state              <= S_FILL;
      x                  <= '0;
      y                  <= '0;
      first_char         <= '0;
      row_latch          <= '0;
      nl_pend            <= 1'b0;
      new_char           <= SPACE;
      new_char_address   <= '0;
      new_char_wen       <= 1'b0;
      new_cursor_wen     <= 1'b0;
      new_first_char_wen <= 1'b0;
    end else begin
      state              <= state_n;
      x                  <= x_n;
      y                  <= y_n;
      first_char         <= fc_n;
      row_latch          <= row_n;
      nl_pend            <= nl_n;
      new_char           <= wr_char_n;
      new_char_address   <= wr_addr_n;
      new_char_wen       <= wr_n;
      new_cursor_wen     <= (x_n != x) || (y_n != y);
      new_first_char_wen <= fcw_n;
    end
  end

  assign new_cursor_x   = x;
  assign new_cursor_y   = y;
  assign new_first_char = first_char;

  vt52_fill_seq #(
    .ADDR_BITS (ADDR_BITS),
    .SIZE      (SIZE)
  ) u_fill (
    .clk    (clk),
    .rstn   (rstn),
    .go     (fill_go),
    .start  (fill_start),
    .count  (fill_count),
    .addr   (fill_addr),
    .strobe (fill_strobe),
    .done   (fill_done)
  );

endmodule

// File: doc/vt52_cmd_engine.md
Name: vt52_cmd_engine

Overview:
Parametrised successor to the terminal command handler. It consumes the byte stream from the async FIFO using a valid/ready handshake and interprets printable characters, control codes and VT52 escape sequences. It drives the char buffer write port, the scroll register and the cursor register. Additions over the previous generation: configurable geometry, a hardware fill sequencer (clear screen / end-of-screen / end-of-line / new bottom row), circular-buffer scrolling, and a screen clear after reset.

Parameters:
ROWS, 25, text rows
COLS, 80, text columns
ROW_BITS, 5, cursor row width
COL_BITS, 7, cursor column width
ADDR_BITS, 11, char buffer address width; ROWS*COLS <= 2**ADDR_BITS is required
TAB_WIDTH, 8, tab stop spacing (used only with TAB_EN)

Ports:
clk  in  1  system/video clock
rstn  in  1  synchronous reset, active low
data  in  8  byte from FIFO
valid  in  1  data valid
ready  out  1  byte accepted when valid && ready
new_first_char  out  ADDR_BITS  scroll base (address of screen row 0)
new_first_char_wen  out  1  one-cycle pulse on scroll
new_char  out  8  char to write
new_char_address  out  ADDR_BITS  write address
new_char_wen  out  1  one-cycle write strobe
new_cursor_x  out  COL_BITS  cursor column
new_cursor_y  out  ROW_BITS  cursor row
new_cursor_wen  out  1  one-cycle pulse when the cursor changes

Behaviour:
- Interface: one clock (clk); rstn is synchronous and active-low.
- Reset (rstn=0 at a clk edge):
  - x=0, y=0, first_char=0.
  - All wen outputs 0, ready=0.
  - Next state is S_FILL over addresses 0..ROWS*COLS-1.
  - A reset asserted mid-fill or mid-escape aborts and restarts this full-screen fill.
- Address: addr(y,x) = (first_char + y*COLS + x) wrapped modulo SIZE = ROWS*COLS. Wrap is implemented as a conditional subtract of SIZE, never a divider.
- Latency: a byte accepted at edge N produces its write and/or cursor pulse at edge N+1. All outputs are registered.
- ready is 1 only in S_IDLE, S_ESC, S_ESC_Y_ROW and S_ESC_Y_COL.
- States: S_IDLE, S_ESC, S_ESC_Y_ROW, S_ESC_Y_COL, S_FILL.
- S_IDLE byte handling:
  - 0x20–0x7E: write the char at addr(y,x).
    - If x<COLS-1, then x++.
    - Otherwise x=0 and a newline follows.
  - 0x0D: x=0.
  - 0x0A: newline.
  - 0x08: x-- (saturates at 0).
  - 0x1B: go to S_ESC.
  - Other bytes are ignored.
- Newline:
  - If y<ROWS-1, then y++.
  - Otherwise scroll:
    - first_char = (first_char+COLS) mod SIZE.
    - Pulse new_first_char_wen.
    - S_FILL the new bottom row (COLS writes).
- S_ESC commands; every one returns to S_IDLE except Y:
  - A: up, saturating.
  - B: down, saturating.
  - C: right, saturating.
  - D: left, saturating.
  - H: home.
  - E: home plus fill of the whole screen.
  - J: fill from addr(y,x) to the end of the screen.
  - K: fill from addr(y,x) to the end of the row.
  - Y: go to S_ESC_Y_ROW.
  - Any other byte is dropped.
- Direct cursor addressing (ESC Y r c):
  - row = r-0x20, col = c-0x20.
  - Each is clamped to ROWS-1 / COLS-1; values below 0x20 clamp to 0.
  - Cursor pulse follows the col byte.
- S_FILL:
  - One write of 0x20 per cycle. The start and length are latched on entry; the address wraps modulo SIZE.
  - The cursor is unchanged by the fill itself.
  - Return to S_IDLE the cycle after the last write.
- Cursor outputs: new_cursor_wen pulses only when x or y changes. First_char and scroll outputs hold their values between pulses.
- Scroll wrap and cursor wrap can occur in the same byte (printable char at x=COLS-1, y=ROWS-1). Order within that byte: char write, then the cursor pulse (x=0, y=ROWS-1) together with the first_char pulse, then the bottom-row fill.

Optional Feature:
TAB_EN
- Defined: 0x09 moves x to the next multiple of TAB_WIDTH, clamped to COLS-1, with a cursor pulse and no write.
- Undefined: 0x09 is ignored like other control codes.

Decomposition:
- Package vt52_pkg holds:
  - Char constants: ESC, CR, LF, BS, HT, SPACE.
  - State enum.
  - The addr_wrap function.
- One sub-module, vt52_fill_seq:
  - Inputs: start address, count, go.
  - Outputs: address/strobe stream and done.
  - Owns the wrap counter.

Test Plan:
1. Release rstn → 2000 writes of 0x20 to addresses 0..1999, ready low throughout, then ready=1. Cursor stays (0,0).
2. After reset, send 'A' (0x41) → write 0x41 @0 at N+1, cursor pulse x=1 y=0.
3. Send ESC Y 0x25 0x2A → cursor pulse y=5 x=10 with no write. Then ESC Y 0x7F 0x7F → clamped to y=24 x=79.
4. With cursor at y=24, send LF:
   - new_first_char=80 pulse.
   - 80 writes of 0x20 @0..79, ready low for those 80 cycles.
   - Next 'B' lands @0+x.
5. Cursor (70,0), first_char=0, send ESC K → writes @70..79 only; then ESC E → 2000 writes and cursor (0,0).
6. Send 'Z' at x=79 y=3 → write @319, cursor (0,4). With TAB_EN, HT at x=3 → x=8; HT at x=78 → x=79.
